unified_mem_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the CPU instruction-fetch port and its data port.
// - Arbitrates simultaneous requests, sequences each access through request, grant and response phases,
//   and routes read data back to the port that owns the access.
// - Sits between the CPU (PC/Instr and ALUResult/WriteData/ReadData/MemWrite) and the memory model.

---
 rtl/unified_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported unified memory between the CPU fetch port (if_*)
// and the CPU data port (d_*). Each access runs IDLE -> ISSUE -> WAIT -> RESP.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; pick an owner and latch its request fields
// ISSUE | one-cycle mem_req strobe; owner's gnt pulses
// WAIT  | waiting for mem_rvalid; timeout counter running
// RESP  | owner's rvalid pulse with registered data (and err on timeout)
//
// Optional feature: define ARB_PERF_CNT_EN to add the stall_if / stall_d
// per-port stall counters. Without it those ports are absent.
//
// All outputs are either registers or decodes of registered state, so there
// is no combinational path from any input to any output.

module unified_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DATA_PRIO = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  output logic          busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   stall_if,
  output logic [31:0]   stall_d
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);
  localparam logic       PRIO_D = (DATA_PRIO != 0);

  logic [1:0]    state;
  logic          own_d;      // 1: data port owns the current access
  logic          last_d;     // 1: last grant went to the data port
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          done_q;     // completion already captured during ISSUE
  logic [3:0]    cnt;
  logic [3:0]    cnt_inc;
  logic          pick_d;
  logic          in_resp;

  assign cnt_inc = cnt + 4'd1;
  assign in_resp = (state == ST_RESP);

  // Winner of the IDLE arbitration: data wins alone, on fixed priority, or
  // on a round-robin tie when fetch was granted last.
  assign pick_d = d_req && (!if_req || PRIO_D || !last_d);

  // Access sequencer: arbitration, field latching, completion and timeout.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      own_d   <= 1'b0;
      last_d  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt     <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= 4'd0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          if (if_req || d_req) begin
            own_d  <= pick_d;
            last_d <= pick_d;
            if (pick_d) begin
              we_q    <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= if_addr;
              wdata_q <= '0;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // An early completion is captured here but still passes through
          // WAIT so the response timing stays uniform.
          if (mem_rvalid) begin
            done_q  <= 1'b1;
            rdata_q <= we_q ? '0 : mem_rdata;
          end
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_q) begin
            state <= ST_RESP;
          end else if (mem_rvalid) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            state   <= ST_RESP;
          end else if (cnt_inc == TO_CNT) begin
            cnt     <= cnt_inc;
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    mem_req   = (state == ST_ISSUE);
    mem_we    = mem_req && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_gnt    = mem_req && !own_d;
    d_gnt     = mem_req && own_d;
    if_rvalid = in_resp && !own_d;
    d_rvalid  = in_resp && own_d;
    if_rdata  = if_rvalid ? rdata_q : '0;
    d_rdata   = d_rvalid ? rdata_q : '0;
    err       = in_resp && err_q;
    busy      = (state != ST_IDLE);
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating stall counters: a port stalls while it requests and is not
  // in its own response cycle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      stall_if <= '0;
      stall_d  <= '0;
    end else begin
      if (if_req && !(in_resp && !own_d) && (stall_if != 32'hFFFF_FFFF))
        stall_if <= stall_if + 32'd1;
      if (d_req && !(in_resp && own_d) && (stall_d != 32'hFFFF_FFFF))
        stall_d <= stall_d + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a per-cycle vector table for the
// fixed-priority instance plus hand-written timeout and round-robin sequences.

module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic        if_req, d_req, d_we, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        rr_if_req, rr_d_req, rr_d_we, rr_mem_rvalid;
  logic [31:0] rr_if_addr, rr_d_addr, rr_d_wdata, rr_mem_rdata;
  logic        rr_if_gnt, rr_if_rvalid, rr_d_gnt, rr_d_rvalid;
  logic        rr_mem_req, rr_mem_we, rr_err, rr_busy;
  logic [31:0] rr_if_rdata, rr_d_rdata, rr_mem_addr, rr_mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .DATA_PRIO(1), .TIMEOUT(15)) dut (
    .clk(clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  unified_mem_arbiter #(.AW(32), .DW(32), .DATA_PRIO(0), .TIMEOUT(15)) dut_rr (
    .clk(clk), .Reset(Reset),
    .if_req(rr_if_req), .if_addr(rr_if_addr), .if_gnt(rr_if_gnt),
    .if_rvalid(rr_if_rvalid), .if_rdata(rr_if_rdata),
    .d_req(rr_d_req), .d_we(rr_d_we), .d_addr(rr_d_addr), .d_wdata(rr_d_wdata),
    .d_gnt(rr_d_gnt), .d_rvalid(rr_d_rvalid), .d_rdata(rr_d_rdata),
    .mem_req(rr_mem_req), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
    .mem_wdata(rr_mem_wdata), .mem_rvalid(rr_mem_rvalid), .mem_rdata(rr_mem_rdata),
    .err(rr_err), .busy(rr_busy)
  );

  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, dwd;
    logic        mrv;
    logic [31:0] mrd;
    logic        ig, irv;
    logic [31:0] ird;
    logic        dg, drv;
    logic [31:0] drd;
    logic        mreq, mwe;
    logic [31:0] maddr, mwd;
    logic        er, bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dwd, input logic mrv, input logic [31:0] mrd,
                     input logic ig, input logic irv, input logic [31:0] ird,
                     input logic dg, input logic drv, input logic [31:0] drd,
                     input logic mreq, input logic mwe, input logic [31:0] maddr,
                     input logic [31:0] mwd, input logic er, input logic bsy);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.mrv = mrv; v.mrd = mrd; v.ig = ig; v.irv = irv; v.ird = ird;
    v.dg = dg; v.drv = drv; v.drd = drd; v.mreq = mreq; v.mwe = mwe;
    v.maddr = maddr; v.mwd = mwd; v.er = er; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  task automatic apply(input int k, input vec_t v);
    @(negedge clk);
    Reset = v.rst; if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_we = v.dw;
    d_addr = v.da; d_wdata = v.dwd; mem_rvalid = v.mrv; mem_rdata = v.mrd;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d if_gnt", k),    32'(if_gnt),    32'(v.ig));
    chk($sformatf("v%0d if_rvalid", k), 32'(if_rvalid), 32'(v.irv));
    chk($sformatf("v%0d if_rdata", k),  if_rdata,       v.ird);
    chk($sformatf("v%0d d_gnt", k),     32'(d_gnt),     32'(v.dg));
    chk($sformatf("v%0d d_rvalid", k),  32'(d_rvalid),  32'(v.drv));
    chk($sformatf("v%0d d_rdata", k),   d_rdata,        v.drd);
    chk($sformatf("v%0d mem_req", k),   32'(mem_req),   32'(v.mreq));
    chk($sformatf("v%0d mem_we", k),    32'(mem_we),    32'(v.mwe));
    chk($sformatf("v%0d mem_addr", k),  mem_addr,       v.maddr);
    chk($sformatf("v%0d mem_wdata", k), mem_wdata,      v.mwd);
    chk($sformatf("v%0d err", k),       32'(err),       32'(v.er));
    chk($sformatf("v%0d busy", k),      32'(busy),      32'(v.bsy));
  endtask

  initial begin
    int n;
    logic got;
    int gcyc[$];
    logic gd[$];

    Reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; mem_rvalid = 0; mem_rdata = 0;
    rr_if_req = 0; rr_d_req = 0; rr_d_we = 0; rr_mem_rvalid = 0;
    rr_if_addr = 32'h500; rr_d_addr = 32'h600; rr_d_wdata = 0; rr_mem_rdata = 32'h1;

    //   rst ir ia        dr dw da        dwd          mrv mrd
    //   | ig irv ird          dg drv drd          mreq mwe maddr     mwd          err busy
    // reset
    add(1, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 0,        0,           0, 0);
    // single fetch 0x100
    add(0, 1, 32'h100,  0, 0, 0,        0,           0, 0,
        1, 0, 0,            0, 0, 0,            1, 0, 32'h100,  0,           0, 1);
    add(0, 0, 32'h100,  0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h100,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           1, 32'h00500093,
        0, 1, 32'h00500093, 0, 0, 0,            0, 0, 32'h100,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h100,  0,           0, 0);
    // tie: data read 0x2000 wins, fetch 0x104 held and granted 4 cycles later
    add(0, 1, 32'h104,  1, 0, 32'h2000, 0,           0, 0,
        0, 0, 0,            1, 0, 0,            1, 0, 32'h2000, 0,           0, 1);
    add(0, 1, 32'h104,  0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h2000, 0,           0, 1);
    add(0, 1, 32'h104,  0, 0, 0,        0,           1, 32'h11112222,
        0, 0, 0,            0, 1, 32'h11112222, 0, 0, 32'h2000, 0,           0, 1);
    add(0, 1, 32'h104,  0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h2000, 0,           0, 0);
    add(0, 1, 32'h104,  0, 0, 0,        0,           0, 0,
        1, 0, 0,            0, 0, 0,            1, 0, 32'h104,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h104,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           1, 32'hAAAA5555,
        0, 1, 32'hAAAA5555, 0, 0, 0,            0, 0, 32'h104,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h104,  0,           0, 0);
    // write 0xDEADBEEF to 0x40: acknowledge returns rdata 0
    add(0, 0, 0,        1, 1, 32'h40,   32'hDEADBEEF, 0, 0,
        0, 0, 0,            1, 0, 0,            1, 1, 32'h40,   32'hDEADBEEF, 0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h40,   32'hDEADBEEF, 0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           1, 32'h12345678,
        0, 0, 0,            0, 1, 0,            0, 0, 32'h40,   32'hDEADBEEF, 0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h40,   32'hDEADBEEF, 0, 0);
    // spurious mem_rvalid in IDLE
    add(0, 0, 0,        0, 0, 0,        0,           1, 32'h5,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h40,   32'hDEADBEEF, 0, 0);
    // reset in WAIT, then a late mem_rvalid, then a normal fetch
    add(0, 0, 0,        1, 0, 32'h80,   0,           0, 0,
        0, 0, 0,            1, 0, 0,            1, 0, 32'h80,   0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h80,   0,           0, 1);
    add(1, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 0,        0,           0, 0);
    add(0, 0, 0,        0, 0, 0,        0,           1, 32'h99,
        0, 0, 0,            0, 0, 0,            0, 0, 0,        0,           0, 0);
    add(0, 1, 32'h200,  0, 0, 0,        0,           0, 0,
        1, 0, 0,            0, 0, 0,            1, 0, 32'h200,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h200,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           1, 32'h0BADF00D,
        0, 1, 32'h0BADF00D, 0, 0, 0,            0, 0, 32'h200,  0,           0, 1);
    add(0, 0, 0,        0, 0, 0,        0,           0, 0,
        0, 0, 0,            0, 0, 0,            0, 0, 32'h200,  0,           0, 0);

    foreach (vecs[i]) apply(i, vecs[i]);

    // Timeout: grant, then 15 WAIT cycles, then RESP with err (16 edges).
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h300; mem_rvalid = 0;
    @(posedge clk); #1;
    chk("to d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk);
    d_req = 0;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (d_rvalid) got = 1;
    end
    chk("to latency", 32'(n), 32'd16);
    chk("to err", 32'(err), 32'd1);
    chk("to d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;
    chk("to idle busy", 32'(busy), 32'd0);
    chk("to idle err", 32'(err), 32'd0);

    // Round-robin: both requests held, memory always ready.
    @(negedge clk);
    rr_if_req = 1; rr_d_req = 1; rr_mem_rvalid = 1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (rr_if_gnt && rr_d_gnt) chk("rr both gnt", 32'd1, 32'd0);
      if (rr_if_gnt || rr_d_gnt) begin
        gcyc.push_back(c);
        gd.push_back(rr_d_gnt);
      end
    end
    chk("rr grant count", 32'(gcyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gcyc.size()) begin
        chk($sformatf("rr g%0d cycle", i), 32'(gcyc[i]), 32'(1 + 4 * i));
        chk($sformatf("rr g%0d is_d", i), 32'(gd[i]), 32'((i % 2) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
